// File: rtl/ctrl_mc_if.sv
// RAM request/ready bus between the control FSM and the memory.
// The controller drives the strobes; the memory answers with ready.
interface ctrl_mc_if;
  logic ram_cs;
  logic ram_we;
  logic ram_oe;
  logic ram_ready;

  modport master (
    output ram_cs, ram_we, ram_oe,
    input  ram_ready
  );

  modport slave (
    input  ram_cs, ram_we, ram_oe,
    output ram_ready
  );
endinterface

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32 control FSM: fetch/decode/execute/mem/write-back
// sequencing with RAM timeout, trap handling and a retire counter.
module ctrl_mc #(
  parameter int ALU_OP_W      = 8,
  parameter int MEM_TIMEOUT   = 15,
  parameter int ENABLE_MULDIV = 1,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  ctrl_mc_if.master           ram,
  output logic                pc_en,
  output logic [1:0]          pc_in_dir,
  output logic                pc_sign,
  output logic                ir_en,
  output logic                reg_en,
  output logic                reg_we,
  output logic [1:0]          reg_in_dir,
  output logic                alu_en,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          op2_dir,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [CNT_W-1:0]    instret
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LDIR, S_DECODE, S_EX, S_WB,
    S_EX_MEM, S_MEM, S_WB_MEM, S_BR, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE
  } cls_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_ADDI = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_DIV  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(10);
  localparam logic [ALU_OP_W-1:0] OP_LUI  = ALU_OP_W'(11);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic MULDIV = (ENABLE_MULDIV != 0);

  state_t state, nxt;
  cls_t cls, dec_cls;
  logic [ALU_OP_W-1:0] op, dec_op;
  logic dec_ok;
  logic [7:0] cnt;
  logic [1:0] cause, tcause;
  logic retire, timeout, taken;

  wire [6:0] opc = instr[6:0];
  wire [2:0] f3  = instr[14:12];
  wire [6:0] f7  = instr[31:25];

  always_comb begin
    dec_ok  = 1'b0;
    dec_cls = C_R;
    dec_op  = OP_ADD;
    case (opc)
      7'b0110011: begin
        dec_ok = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: dec_op = OP_ADD;
          {7'h20, 3'b000}: dec_op = OP_SUB;
          {7'h00, 3'b001}: dec_op = OP_SLL;
          {7'h00, 3'b101}: dec_op = OP_SRL;
          {7'h00, 3'b111}: dec_op = OP_AND;
          {7'h00, 3'b110}: dec_op = OP_OR;
          {7'h00, 3'b100}: dec_op = OP_XOR;
          {7'h01, 3'b000}: begin dec_op = OP_MUL; dec_ok = MULDIV; end
          {7'h01, 3'b100}: begin dec_op = OP_DIV; dec_ok = MULDIV; end
          default:         dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_cls = C_ADDI; dec_op = OP_ADDI; dec_ok = (f3 == 3'b000);
      end
      7'b0110111: begin
        dec_cls = C_LUI; dec_op = OP_LUI; dec_ok = 1'b1;
      end
      7'b0000011: begin dec_cls = C_LW; dec_ok = (f3 == 3'b010); end
      7'b0100011: begin dec_cls = C_SW; dec_ok = (f3 == 3'b010); end
      7'b1100011: begin
        dec_cls = f3[0] ? C_BNE : C_BEQ;
        dec_ok  = (f3[2:1] == 2'b00);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cause   <= '0;
      instret <= '0;
      cls     <= C_R;
      op      <= OP_ADD;
    end else begin
      state <= nxt;
      // counter restarts whenever a new state is entered
      cnt <= (state == nxt) ? cnt + 8'd1 : 8'd0;
      if (state == S_DECODE) begin
        cls <= dec_cls;
        op  <= dec_op;
      end
      if (nxt == S_TRAP && state != S_TRAP) cause <= tcause;
      if (retire) instret <= instret + 1'b1;
    end
  end

  assign timeout = !ram.ram_ready && (cnt == TO_LAST);
  assign taken   = (cls == C_BEQ) ? alu_zero : !alu_zero;
  assign pc_sign = 1'b0;

  always_comb begin
    nxt         = state;
    tcause      = 2'b00;
    retire      = 1'b0;
    ram.ram_cs  = 1'b0;
    ram.ram_we  = 1'b0;
    ram.ram_oe  = 1'b0;
    pc_en       = 1'b0;
    pc_in_dir   = 2'b00;
    ir_en       = 1'b0;
    reg_en      = 1'b0;
    reg_we      = 1'b0;
    reg_in_dir  = 2'b00;
    alu_en      = 1'b0;
    alu_op      = '0;
    op2_dir     = 2'b00;
    fault       = 1'b0;
    fault_cause = 2'b00;
    case (state)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        ram.ram_cs = 1'b1;
        ram.ram_oe = 1'b1;
        if (ram.ram_ready) nxt = S_LDIR;
        else if (timeout) begin nxt = S_TRAP; tcause = 2'b10; end
      end
      S_LDIR: begin
        ir_en = 1'b1;
        pc_en = 1'b1;
        nxt   = S_DECODE;
      end
      S_DECODE: begin
        if (!dec_ok) begin
          nxt = S_TRAP; tcause = 2'b01;
        end else begin
          case (dec_cls)
            C_LW, C_SW:   nxt = S_EX_MEM;
            C_BEQ, C_BNE: nxt = S_BR;
            default:      nxt = S_EX;
          endcase
        end
      end
      S_EX: begin
        alu_en  = 1'b1;
        alu_op  = op;
        op2_dir = (cls == C_ADDI) ? 2'b10 :
                  (cls == C_LUI)  ? 2'b01 : 2'b00;
        nxt     = S_WB;
      end
      S_WB: begin
        reg_en = 1'b1; reg_we = 1'b1; reg_in_dir = 2'b10;
        retire = 1'b1;
        nxt    = run ? S_FETCH : S_IDLE;
      end
      S_EX_MEM: begin
        alu_en  = 1'b1;
        alu_op  = OP_ADD;
        op2_dir = (cls == C_SW) ? 2'b11 : 2'b10;
        nxt     = S_MEM;
      end
      S_MEM: begin
        ram.ram_cs = 1'b1;
        ram.ram_we = (cls == C_SW);
        ram.ram_oe = (cls != C_SW);
        if (ram.ram_ready) begin
          if (cls == C_SW) begin
            retire = 1'b1;
            nxt    = run ? S_FETCH : S_IDLE;
          end else nxt = S_WB_MEM;
        end else if (timeout) begin
          nxt = S_TRAP; tcause = 2'b10;
        end
      end
      S_WB_MEM: begin
        reg_en = 1'b1; reg_we = 1'b1; reg_in_dir = 2'b01;
        retire = 1'b1;
        nxt    = run ? S_FETCH : S_IDLE;
      end
      S_BR: begin
        alu_en    = 1'b1;
        alu_op    = OP_SUB;
        pc_en     = taken;
        pc_in_dir = taken ? 2'b01 : 2'b00;
        retire    = 1'b1;
        nxt       = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        fault       = 1'b1;
        fault_cause = cause;
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed scoreboard bench for ctrl_mc: expected output vectors are
// queued per segment and popped/compared once per clock.
module tb_ctrl_mc;
  logic clk = 1'b0;
  logic rst, run, ready, zero;
  logic [31:0] instr;
  always #5 clk = ~clk;

  ctrl_mc_if b0 ();
  ctrl_mc_if b1 ();
  assign b0.ram_ready = ready;
  assign b1.ram_ready = ready;

  logic pc_en, pc_sign, ir_en, reg_en, reg_we, alu_en, fault;
  logic [1:0] pc_in_dir, reg_in_dir, op2_dir, fault_cause;
  logic [7:0] alu_op;
  logic [31:0] instret;
  logic pc_en1, pc_sign1, ir_en1, reg_en1, reg_we1, alu_en1, fault1;
  logic [1:0] pc_in_dir1, reg_in_dir1, op2_dir1, fault_cause1;
  logic [7:0] alu_op1;
  logic [31:0] instret1;

  ctrl_mc #(.ENABLE_MULDIV(1)) u0 (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .alu_zero(zero),
    .ram(b0.master), .pc_en(pc_en), .pc_in_dir(pc_in_dir),
    .pc_sign(pc_sign), .ir_en(ir_en), .reg_en(reg_en), .reg_we(reg_we),
    .reg_in_dir(reg_in_dir), .alu_en(alu_en), .alu_op(alu_op),
    .op2_dir(op2_dir), .fault(fault), .fault_cause(fault_cause),
    .instret(instret)
  );

  ctrl_mc #(.ENABLE_MULDIV(0)) u1 (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .alu_zero(zero),
    .ram(b1.master), .pc_en(pc_en1), .pc_in_dir(pc_in_dir1),
    .pc_sign(pc_sign1), .ir_en(ir_en1), .reg_en(reg_en1),
    .reg_we(reg_we1), .reg_in_dir(reg_in_dir1), .alu_en(alu_en1),
    .alu_op(alu_op1), .op2_dir(op2_dir1), .fault(fault1),
    .fault_cause(fault_cause1), .instret(instret1)
  );

  wire [24:0] obs = {b0.ram_cs, b0.ram_we, b0.ram_oe, pc_en, pc_in_dir,
                     ir_en, reg_en, reg_we, reg_in_dir, alu_en, alu_op,
                     op2_dir, fault, fault_cause};

  int passed = 0;
  int total  = 0;
  logic [24:0] q[$];
  string tq[$];

  function automatic logic [24:0] ov(
    input logic [2:0] rm, input logic [2:0] pc, input logic ir,
    input logic [3:0] rg, input logic ae, input logic [7:0] op,
    input logic [1:0] o2, input logic [2:0] f);
    return {rm, pc, ir, rg, ae, op, o2, f};
  endfunction

  localparam logic [24:0] E_IDLE  = '0;
  localparam logic [24:0] E_FETCH = {3'b101, 22'd0};
  localparam logic [24:0] E_LDIR  = {3'b000, 3'b100, 1'b1, 18'd0};
  localparam logic [24:0] E_WB    = {7'd0, 4'b1110, 14'd0};
  localparam logic [24:0] E_WBMEM = {7'd0, 4'b1101, 14'd0};

  function automatic logic [24:0] e_ex(input logic [7:0] op,
                                       input logic [1:0] o2);
    return ov(3'b0, 3'b0, 1'b0, 4'b0, 1'b1, op, o2, 3'b0);
  endfunction
  function automatic logic [24:0] e_mem(input logic we);
    return ov(we ? 3'b110 : 3'b101, 3'b0, 1'b0, 4'b0, 1'b0, 8'd0,
              2'b0, 3'b0);
  endfunction
  function automatic logic [24:0] e_br(input logic t);
    return ov(3'b0, t ? 3'b101 : 3'b000, 1'b0, 4'b0, 1'b1, 8'd2,
              2'b0, 3'b0);
  endfunction
  function automatic logic [24:0] e_trap(input logic [1:0] c);
    return ov(3'b0, 3'b0, 1'b0, 4'b0, 1'b0, 8'd0, 2'b0, {1'b1, c});
  endfunction

  task automatic push(input logic [24:0] v, input string t);
    q.push_back(v);
    tq.push_back(t);
  endtask

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, o, e);
  endtask

  // one clock: drive inputs, then compare outputs against the queue head
  task automatic cyc(input logic rs, input logic rn, input logic rd,
                     input logic z);
    logic [24:0] e;
    string t;
    @(negedge clk);
    rst = rs; run = rn; ready = rd; zero = z;
    #1;
    if (q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = q.pop_front();
      t = tq.pop_front();
      chk(t, {7'd0, obs}, {7'd0, e});
    end
  endtask

  task automatic front();
    push(E_FETCH, "fetch");
    push(E_LDIR, "ldir");
    push(E_IDLE, "decode");
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
  endtask

  logic [31:0] ops_i[10] = '{32'h002081B3, 32'h402081B3, 32'h002091B3,
    32'h0020D1B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3,
    32'h000051B7, 32'h022080B3, 32'h0220C0B3};
  logic [7:0] ops_o[10] = '{8'd0, 8'd2, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10,
    8'd11, 8'd3, 8'd4};

  initial begin
    rst = 1; run = 0; ready = 0; zero = 0; instr = 32'h00500093;
    repeat (2) @(posedge clk);

    // addi x1,x0,5
    push(E_IDLE, "reset_idle");
    cyc(0, 1, 1, 0);
    chk("reset_instret", instret, 0);
    chk("reset_fault", {31'd0, fault}, 0);
    chk("pc_sign", {31'd0, pc_sign}, 0);
    front();
    push(e_ex(8'd1, 2'b10), "addi_ex");
    push(E_WB, "addi_wb");
    push(E_IDLE, "addi_idle");
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("addi_instret", instret, 1);

    // lw with 3 wait states
    instr = 32'h0000A103;
    push(E_IDLE, "lw_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_ex(8'd0, 2'b10), "lw_exmem");
    for (int i = 0; i < 4; i++) push(e_mem(1'b0), "lw_mem");
    push(E_WBMEM, "lw_wbmem");
    push(E_IDLE, "lw_done");
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("lw_instret", instret, 2);

    // sw
    instr = 32'h0020A023;
    push(E_IDLE, "sw_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_ex(8'd0, 2'b11), "sw_exmem");
    push(e_mem(1'b1), "sw_mem");
    push(E_IDLE, "sw_done");
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("sw_instret", instret, 3);

    // beq taken, beq not taken, bne taken
    instr = 32'h00208463;
    push(E_IDLE, "br_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_br(1'b1), "beq_taken");
    cyc(0, 1, 1, 1);
    front();
    push(e_br(1'b0), "beq_not");
    cyc(0, 1, 1, 0);
    instr = 32'h00209463;
    front();
    push(e_br(1'b1), "bne_taken");
    push(E_IDLE, "br_done");
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("br_instret", instret, 6);

    // back-to-back ALU ops; u1 has MUL/DIV disabled
    push(E_IDLE, "ops_idle");
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      instr = ops_i[i];
      front();
      push(e_ex(ops_o[i], (i == 7) ? 2'b01 : 2'b00), "op_ex");
      push(E_WB, "op_wb");
      cyc(0, 1, 1, 0);
      chk("nomuldiv_fault", {31'd0, fault1}, {31'd0, i >= 8});
      cyc(0, i != 9, 1, 0);
    end
    push(E_IDLE, "ops_done");
    cyc(0, 0, 1, 0);
    chk("ops_instret", instret, 16);
    chk("nomuldiv_cause", {30'd0, fault_cause1}, 1);

    // run dropped during EX
    instr = 32'h002081B3;
    push(E_IDLE, "stop_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_ex(8'd0, 2'b00), "stop_ex");
    push(E_WB, "stop_wb");
    push(E_IDLE, "stop_done");
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("stop_instret", instret, 17);

    // reset while in MEM
    instr = 32'h0000A103;
    push(E_IDLE, "rmem_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_ex(8'd0, 2'b10), "rmem_exmem");
    push(e_mem(1'b0), "rmem_mem");
    push(E_IDLE, "rmem_reset");
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rmem_instret", instret, 0);

    // fetch timeout
    push(E_IDLE, "to_idle");
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) push(E_FETCH, "to_fetch");
    for (int i = 0; i < 3; i++) push(e_trap(2'b10), "to_trap");
    push(e_trap(2'b10), "to_trap_rst");
    push(E_IDLE, "to_after_rst");
    repeat (15) cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("to_instret", instret, 0);

    // illegal encoding
    instr = 32'hFFFFFFFF;
    push(E_IDLE, "ill_idle");
    cyc(0, 1, 1, 0);
    front();
    push(e_trap(2'b01), "ill_trap");
    push(e_trap(2'b01), "ill_trap2");
    push(e_trap(2'b01), "ill_trap_rst");
    push(E_IDLE, "ill_after_rst");
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ill_fault", {31'd0, fault}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
Second-generation multi-cycle control FSM for the RV32 core. It sequences fetch, decode, execute, memory and write-back, and drives the RAM, PC, IR, register-file and ALU control lines. Over the first-generation controller it adds:
- synchronous reset and a run gate
- a ready handshake with timeout on RAM accesses
- LW/SW, BEQ/BNE, AND/OR/XOR
- an optional MUL/DIV build switch
- illegal-instruction and bus-fault trapping
- a retired-instruction counter

Parameters:
ALU_OP_W, 8, width of alu_op
MEM_TIMEOUT, 15, max cycles waiting for ram_ready before fault (1..255)
ENABLE_MULDIV, 1, 0 makes MUL/DIV decode as illegal
CNT_W, 32, width of instret

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
run  in  1  level; leaves IDLE when 1
instr  in  32  IR contents (valid from DECODE onward)
ram_ready  in  1  RAM access complete this cycle
alu_zero  in  1  ALU result==0 (valid in BR state)
ram_cs/ram_we/ram_oe  out  1 each  RAM chip select / write / read enable
pc_en  out  1  PC load this edge
pc_in_dir  out  2  00 pc+4, 01 fetch_pc+B-imm
pc_sign  out  1  tied 0 (reserved)
ir_en  out  1  IR load
reg_en/reg_we  out  1 each  regfile enable/write
reg_in_dir  out  2  01 RAM data, 10 ALU result
alu_en  out  1  ALU enable
alu_op  out  ALU_OP_W  ADD0 ADDI1 SUB2 MUL3 DIV4 SLL5 SRL6 AND7 OR8 XOR10 LUI11
op2_dir  out  2  00 rs2, 01 U-imm, 10 I-imm, 11 S-imm
fault  out  1  sticky trap flag
fault_cause  out  2  01 illegal instr, 10 RAM timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- Outputs are Moore: decoded from the registered state plus latched decode. Every output is 0 in any state that does not name it; no latches.
- Reset: rst=1 at an edge sets state=IDLE, timeout counter=0, fault=0, fault_cause=00, instret=0. rst overrides everything, including mid-access and TRAP.

States:
- IDLE: all outputs 0.
  - run=1 -> FETCH.
- FETCH: ram_cs=ram_oe=1.
  - ram_ready=1 -> LDIR.
  - else the counter increments; at count==MEM_TIMEOUT-1 -> TRAP with cause 10.
- LDIR: ir_en=1, pc_en=1, pc_in_dir=00, then -> DECODE. fetch_pc is captured internally by the datapath.
- DECODE: all outputs 0. Latch op class and alu_op from instr, then:
  - R-type, ADDI or LUI -> EX
  - LW (opc 0000011, f3 010) / SW (0100011, f3 010) -> EX_MEM
  - BEQ/BNE (1100011, f3 000/001) -> BR
  - any other encoding -> TRAP with cause 01; MUL/DIV also trap here when ENABLE_MULDIV=0
- EX: alu_en=1 with the latched alu_op; op2_dir = 00 for R-type, 10 for ADDI, 01 for LUI. -> WB.
- WB: reg_en=reg_we=1, reg_in_dir=10. Retire. -> next.
- EX_MEM: alu_en=1, alu_op=ADD, op2_dir=10 (LW) or 11 (SW). -> MEM.
- MEM: ram_cs=1; ram_oe=1 (LW) or ram_we=1 (SW). Same ready/timeout rule as FETCH.
  - On ready: LW -> WB_MEM; SW retires -> next.
- WB_MEM: reg_en=reg_we=1, reg_in_dir=01. Retire. -> next.
- BR: alu_en=1, alu_op=SUB, op2_dir=00.
  - Taken (BEQ with alu_zero=1, BNE with alu_zero=0): pc_en=1, pc_in_dir=01.
  - Retire. -> next.
- "next": FETCH if run=1, else IDLE. A stop is only honoured at an instruction boundary.
- TRAP: all outputs 0 except fault=1 and fault_cause (held). No exit except rst.

Timeout counter and retire:
- The counter clears on entering FETCH or MEM.
- With ram_ready=1 on the first cycle, FETCH and MEM last 1 cycle.
- Retire means instret += 1, wrapping modulo 2^CNT_W.

Latency with zero wait states: ALU ops 5 cycles, LW 6, SW 5, branch 4.

Test Plan:
- Reset then run=1, ram_ready=1, instr=0x00500093 (addi x1,x0,5) -> states IDLE,FETCH,LDIR,DECODE,EX(alu_op=1,op2_dir=10),WB(reg_in_dir=10); instret=1 after 5 cycles.
- ram_ready held 0 in FETCH, MEM_TIMEOUT=15 -> TRAP entered after exactly 15 FETCH cycles, fault=1, cause=10, stays until rst, then outputs all 0 and instret=0.
- instr=0x0000A103 (lw x2,0(x1)) with ram_ready 0 for 3 MEM cycles then 1 -> MEM lasts 4 cycles with ram_oe=1, then WB_MEM reg_in_dir=01; total 9 cycles.
- instr=0x00208463 (beq x1,x2,8): alu_zero=1 -> BR pc_en=1, pc_in_dir=01; alu_zero=0 -> pc_en=0; both retire.
- ENABLE_MULDIV=0, instr=0x022080B3 (mul) -> TRAP cause=01; ENABLE_MULDIV=1 -> EX alu_op=3.
- run dropped during EX of an ADD -> WB completes, then IDLE; rst asserted in MEM with ram_cs=1 -> next cycle IDLE, all outputs 0.
